// File: rtl/rf_wport_arbiter.sv
// Purpose: shares the single GRF write port between W-stage writeback (priority) and a 2-entry aux result FIFO.
// Latency: W writes pass through combinationally; an aux result reaches the GRF no earlier than the cycle after acceptance.
// Backpressure: aux_ready drops when the FIFO is full with no pop, or while stall_req is forcing W to drain.
module rf_wport_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        w_we,
    input  logic [4:0]  w_a3,
    input  logic [31:0] w_wd,
    input  logic        aux_valid,
    input  logic [4:0]  aux_a3,
    input  logic [31:0] aux_wd,
    output logic        aux_ready,
    output logic        rf_we,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd,
    output logic        stall_req,
    output logic [1:0]  pend_vld,
    output logic [4:0]  pend_a3_0,
    output logic [4:0]  pend_a3_1
);

    typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

    typedef struct packed {
        logic [4:0]  a3;
        logic [31:0] wd;
    } ent_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    logic [3:0] cnt;
    logic [1:0] vld;
    ent_t       ent [2];

    logic       w_wr;
    logic       pop;
    logic       head_kill;
    logic       head_blocked;
    logic       accept;
    logic [3:0] cnt_nxt;
    logic [2:0] c_vld;
    ent_t       c_ent [3];
    logic [1:0] nxt_vld;
    ent_t       nxt_ent [2];

    assign w_wr         = w_we && (w_a3 != 5'd0);
    assign pop          = vld[0] && !w_wr;
    assign head_kill    = w_wr && vld[0] && (ent[0].a3 == w_a3);
    assign head_blocked = w_wr && vld[0] && !head_kill;

    // Entries are kept compacted toward slot 0, so full means both bits set.
    assign aux_ready = (state != FORCE) && (!(&vld) || pop);
    assign accept    = aux_valid && aux_ready;

    assign pend_vld  = vld;
    assign pend_a3_0 = ent[0].a3;
    assign pend_a3_1 = ent[1].a3;

    always_comb begin
        rf_we = 1'b0;
        rf_a3 = 5'd0;
        rf_wd = 32'd0;
        if (reset_n) begin
            if (w_wr) begin
                rf_we = 1'b1;
                rf_a3 = w_a3;
                rf_wd = w_wd;
            end else if (pop && (ent[0].a3 != 5'd0)) begin
                rf_we = 1'b1;
                rf_a3 = ent[0].a3;
                rf_wd = ent[0].wd;
            end
        end
    end

    always_comb begin
        cnt_nxt = cnt;
        if (head_blocked) begin
            cnt_nxt = (cnt == 4'hF) ? cnt : cnt + 4'd1;
        end else if (pop || head_kill) begin
            cnt_nxt = 4'd0;
        end
    end

    // Candidate list in program order: surviving FIFO entries, then the incoming result.
    always_comb begin
        if (pop) begin
            c_vld[0] = vld[1];
            c_ent[0] = ent[1];
            c_vld[1] = 1'b0;
            c_ent[1] = '0;
        end else begin
            c_vld[0] = vld[0];
            c_ent[0] = ent[0];
            c_vld[1] = vld[1];
            c_ent[1] = ent[1];
        end
        c_vld[2] = accept;
        c_ent[2] = '{a3: aux_a3, wd: aux_wd};

        // The W instruction is younger than every aux result: matching entries are dead.
        for (int i = 0; i < 3; i++) begin
            if (w_wr && (c_ent[i].a3 == w_a3)) begin
                c_vld[i] = 1'b0;
            end
        end

        nxt_vld    = 2'b00;
        nxt_ent[0] = '0;
        nxt_ent[1] = '0;
        for (int i = 0; i < 3; i++) begin
            if (c_vld[i]) begin
                if (!nxt_vld[0]) begin
                    nxt_vld[0] = 1'b1;
                    nxt_ent[0] = c_ent[i];
                end else begin
                    nxt_vld[1] = 1'b1;
                    nxt_ent[1] = c_ent[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld       <= 2'b00;
            ent[0]    <= '0;
            ent[1]    <= '0;
            state     <= IDLE;
            cnt       <= 4'd0;
            stall_req <= 1'b0;
        end else begin
            vld    <= nxt_vld;
            ent[0] <= nxt_ent[0];
            ent[1] <= nxt_ent[1];
            case (state)
                IDLE: begin
                    cnt <= 4'd0;
                    if (nxt_vld[0]) begin
                        state <= PEND;
                    end
                end
                PEND: begin
                    if (!nxt_vld[0]) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt_nxt;
                        if (cnt == LIMIT) begin
                            state     <= FORCE;
                            stall_req <= 1'b1;
                        end
                    end
                end
                FORCE: begin
                    if (!nxt_vld[0]) begin
                        state     <= IDLE;
                        cnt       <= 4'd0;
                        stall_req <= 1'b0;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= 4'd0;
                    stall_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Bench for rf_wport_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_rf_wport_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        w_we = 1'b0;
    logic [4:0]  w_a3 = 5'd0;
    logic [31:0] w_wd = 32'd0;
    logic        aux_valid = 1'b0;
    logic [4:0]  aux_a3 = 5'd0;
    logic [31:0] aux_wd = 32'd0;
    logic        aux_ready;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic        stall_req;
    logic [1:0]  pend_vld;
    logic [4:0]  pend_a3_0;
    logic [4:0]  pend_a3_1;

    always #5 clk = ~clk;

    rf_wport_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .w_we      (w_we),
        .w_a3      (w_a3),
        .w_wd      (w_wd),
        .aux_valid (aux_valid),
        .aux_a3    (aux_a3),
        .aux_wd    (aux_wd),
        .aux_ready (aux_ready),
        .rf_we     (rf_we),
        .rf_a3     (rf_a3),
        .rf_wd     (rf_wd),
        .stall_req (stall_req),
        .pend_vld  (pend_vld),
        .pend_a3_0 (pend_a3_0),
        .pend_a3_1 (pend_a3_1)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  a3;
        logic [31:0] wd;
    } pe_t;

    pe_t q[$];
    int  m_cnt = 0;
    bit  m_force = 1'b0;

    logic        obs_we, obs_ready, obs_stall;
    logic [4:0]  obs_a3, obs_p0, obs_p1;
    logic [31:0] obs_wd;
    logic [1:0]  obs_pv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit we, input logic [4:0] a3, input logic [31:0] wd,
                        input bit av, input logic [4:0] aa3, input logic [31:0] awd);
        bit          w_wr, pop, ready, hkill, blocked, e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        logic [1:0]  e_pv;
        pe_t         e;
        @(negedge clk);
        w_we = we; w_a3 = a3; w_wd = wd;
        aux_valid = av; aux_a3 = aa3; aux_wd = awd;
        #1;
        w_wr  = we && (a3 != 5'd0);
        pop   = !w_wr && (q.size() > 0);
        ready = !m_force && ((q.size() < 2) || pop);
        e_we = 1'b0; e_a3 = 5'd0; e_wd = 32'd0;
        if (w_wr) begin
            e_we = 1'b1; e_a3 = a3; e_wd = wd;
        end else if (pop && q[0].a3 != 5'd0) begin
            e_we = 1'b1; e_a3 = q[0].a3; e_wd = q[0].wd;
        end
        e_pv = (q.size() == 0) ? 2'b00 : (q.size() == 1) ? 2'b01 : 2'b11;
        check("rf_we", rf_we, e_we);
        check("rf_a3", rf_a3, e_a3);
        check("rf_wd", rf_wd, e_wd);
        check("aux_ready", aux_ready, ready);
        check("stall_req", stall_req, m_force);
        check("pend_vld", pend_vld, e_pv);
        check("pend_a3_0", pend_a3_0, (q.size() > 0) ? q[0].a3 : 5'd0);
        check("pend_a3_1", pend_a3_1, (q.size() > 1) ? q[1].a3 : 5'd0);
        obs_we = rf_we; obs_a3 = rf_a3; obs_wd = rf_wd; obs_ready = aux_ready;
        obs_stall = stall_req; obs_pv = pend_vld; obs_p0 = pend_a3_0; obs_p1 = pend_a3_1;

        // Model advances to the state the coming rising edge will produce.
        hkill   = w_wr && (q.size() > 0) && (q[0].a3 == a3);
        blocked = w_wr && (q.size() > 0) && !hkill;
        if (pop) q.delete(0);
        if (w_wr) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].a3 == a3) q.delete(i);
            end
        end
        if (av && ready && !(w_wr && aa3 == a3)) begin
            e.a3 = aa3; e.wd = awd;
            q.push_back(e);
        end
        if (q.size() == 0) begin
            m_cnt = 0; m_force = 1'b0;
        end else begin
            if (!m_force && m_cnt == LIMIT) m_force = 1'b1;
            if (blocked) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
            else if (pop || hkill) m_cnt = 0;
        end
    endtask

    task automatic apply_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_rf_a3", rf_a3, 5'd0);
        check("rst_rf_wd", rf_wd, 32'd0);
        check("rst_aux_ready", aux_ready, 1'b1);
        check("rst_stall", stall_req, 1'b0);
        check("rst_pend_vld", pend_vld, 2'b00);
        check("rst_pend_a3_0", pend_a3_0, 5'd0);
        check("rst_pend_a3_1", pend_a3_1, 5'd0);
        q.delete();
        m_cnt = 0;
        m_force = 1'b0;
        @(negedge clk);
        w_we = 1'b0; aux_valid = 1'b0;
        reset_n = 1'b1;
    endtask

    initial begin
        int first;
        int bias;
        apply_reset();

        // Reset in PEND with two queued entries while W is still writing.
        step(1, 9, 32'h9, 1, 3, 32'h33);
        step(1, 9, 32'h9, 1, 4, 32'h44);
        step(1, 9, 32'h9, 0, 0, 0);
        check("t1_full_before_rst", obs_pv, 2'b11);
        apply_reset();

        // Aux result to $8 with W idle writes one cycle later.
        step(0, 0, 0, 1, 8, 32'h1234);
        step(0, 0, 0, 0, 0, 0);
        check("t2_we", obs_we, 1'b1);
        check("t2_a3", obs_a3, 5'd8);
        check("t2_wd", obs_wd, 32'h1234);
        step(0, 0, 0, 0, 0, 0);
        check("t2_drained", obs_pv, 2'b00);
        apply_reset();

        // Starvation: stall raised five cycles after enqueue, dropped one cycle after the drain.
        step(0, 0, 0, 1, 5, 32'h55);
        first = -1;
        for (int k = 0; k < 8; k++) begin
            step(1, 9, 32'(k), 0, 0, 0);
            if (obs_stall && first < 0) first = k;
        end
        check("t3_stall_latency", 32'(first), 32'd5);
        step(0, 0, 0, 0, 0, 0);
        check("t3_drain_we", obs_we, 1'b1);
        check("t3_drain_a3", obs_a3, 5'd5);
        check("t3_stall_during_drain", obs_stall, 1'b1);
        step(0, 0, 0, 0, 0, 0);
        check("t3_stall_cleared", obs_stall, 1'b0);
        apply_reset();

        // WAW kill of the head entry by a W write to the same register.
        step(1, 9, 32'h9, 1, 3, 32'h33);
        step(1, 9, 32'h9, 1, 4, 32'h44);
        step(1, 3, 32'h3333, 0, 0, 0);
        check("t4_w_a3", obs_a3, 5'd3);
        check("t4_w_wd", obs_wd, 32'h3333);
        step(1, 9, 32'h9, 0, 0, 0);
        check("t4_pend_vld", obs_pv, 2'b01);
        check("t4_pend_a3_0", obs_p0, 5'd4);
        apply_reset();

        // Aux write to $0 is discarded.
        step(0, 0, 0, 1, 0, 32'hdead);
        step(0, 0, 0, 0, 0, 0);
        check("t5_we", obs_we, 1'b0);
        check("t5_pend_vld", obs_pv, 2'b01);
        step(0, 0, 0, 0, 0, 0);
        check("t5_drained", obs_pv, 2'b00);
        apply_reset();

        // Full FIFO accepts while popping.
        step(1, 9, 32'h9, 1, 3, 32'h33);
        step(1, 9, 32'h9, 1, 4, 32'h44);
        step(0, 0, 0, 1, 7, 32'h77);
        check("t6_ready", obs_ready, 1'b1);
        check("t6_pop_a3", obs_a3, 5'd3);
        step(1, 9, 32'h9, 0, 0, 0);
        check("t6_pend_vld", obs_pv, 2'b11);
        check("t6_pend_a3_0", obs_p0, 5'd4);
        check("t6_pend_a3_1", obs_p1, 5'd7);
        apply_reset();

        // Randomized traffic with shifting W load and a small register space for collisions.
        bias = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 100 == 0) bias = (n / 100) % 3 == 0 ? 20 : ((n / 100) % 3 == 1 ? 60 : 95);
            step($urandom_range(0, 99) < bias, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 499) == 0) apply_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
